// File: rtl/player_motion_ctrl_if.sv
// Frame strobe, keycode and player position bundle between the keyboard
// front end, the motion controller and the sprite/colour mapper.
interface player_motion_ctrl_if #(
    parameter int DATA_W = 10
);
    logic              frame_clk;
    logic [7:0]        keycode;
    logic [DATA_W-1:0] PosX;
    logic [DATA_W-1:0] PosY;
    logic              airborne;
    logic              frame_tick;

    modport master (
        output frame_clk,
        output keycode,
        input  PosX,
        input  PosY,
        input  airborne,
        input  frame_tick
    );

    modport slave (
        input  frame_clk,
        input  keycode,
        output PosX,
        output PosY,
        output airborne,
        output frame_tick
    );
endinterface

// File: rtl/player_motion_ctrl.sv
// Per-frame player motion: A/D horizontal stepping with edge clamping and a
// gravity-driven W jump, updated once per synchronised frame_clk rising edge.
module player_motion_ctrl #(
    parameter int DATA_W   = 10,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 631,
    parameter int X_START  = 320,
    parameter int Y_GROUND = 400,
    parameter int X_STEP   = 2,
    parameter int JUMP_VEL = 12,
    parameter int GRAVITY  = 1
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    player_motion_ctrl_if.slave  bus
);

    localparam logic [1:0] GROUND  = 2'd0;
    localparam logic [1:0] RISING  = 2'd1;
    localparam logic [1:0] FALLING = 2'd2;

    localparam logic [7:0] KEY_A = 8'd4;
    localparam logic [7:0] KEY_D = 8'd7;
    localparam logic [7:0] KEY_W = 8'd26;

    // Two guard bits keep position + velocity sums free of wrap in both directions.
    localparam int SW = DATA_W + 2;

    localparam logic signed [SW-1:0]     XMIN_S   = SW'(X_MIN);
    localparam logic signed [SW-1:0]     XMAX_S   = SW'(X_MAX);
    localparam logic signed [SW-1:0]     XSTEP_S  = SW'(X_STEP);
    localparam logic signed [SW-1:0]     YGND_S   = SW'(Y_GROUND);
    localparam logic signed [DATA_W-1:0] JUMP_V   = DATA_W'(-JUMP_VEL);
    localparam logic signed [DATA_W-1:0] GRAV_V   = DATA_W'(GRAVITY);
    localparam logic [DATA_W-1:0]        X_START_U = DATA_W'(X_START);
    localparam logic [DATA_W-1:0]        Y_GND_U   = DATA_W'(Y_GROUND);

    function automatic logic [DATA_W-1:0] sat_x(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] c;
        c = v;
        if (v < XMIN_S)
            c = XMIN_S;
        else if (v > XMAX_S)
            c = XMAX_S;
        return c[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] move_x(input logic [DATA_W-1:0] x,
                                                 input logic [7:0]        key);
        logic signed [SW-1:0] nx;
        nx = $signed({2'b00, x});
        if (key == KEY_A)
            nx = nx - XSTEP_S;
        else if (key == KEY_D)
            nx = nx + XSTEP_S;
        return sat_x(nx);
    endfunction

    logic                     frame_sync_p0;
    logic                     frame_sync_p1;
    logic                     frame_sync_p2;
    logic                     tick;
    logic                     vld_p3;

    logic [DATA_W-1:0]        pos_x;
    logic [DATA_W-1:0]        pos_y;
    logic signed [DATA_W-1:0] vel_y;
    logic [1:0]               state;
    logic [7:0]               prev_key;

    logic signed [SW-1:0]     y_sum;
    logic signed [DATA_W-1:0] vel_inc;
    logic [DATA_W-1:0]        pos_y_n;
    logic signed [DATA_W-1:0] vel_n;
    logic [1:0]               state_n;
    logic                     jump_press;

    // ---- stage p0..p2: frame strobe synchroniser and rising-edge detect ----
    assign tick = frame_sync_p1 & ~frame_sync_p2;

    // ---- vertical next-state, consumed only on tick ----
    always_comb begin
        y_sum      = $signed({2'b00, pos_y}) + $signed({{2{vel_y[DATA_W-1]}}, vel_y});
        vel_inc    = vel_y + GRAV_V;
        jump_press = (bus.keycode == KEY_W) && (prev_key != KEY_W);
        pos_y_n    = pos_y;
        vel_n      = vel_y;
        state_n    = state;
        case (state)
            GROUND: begin
                if (jump_press) begin
                    vel_n   = JUMP_V;
                    state_n = RISING;
                end
            end
            RISING: begin
                // Hitting the top of the screen kills the upward speed at once.
                if (y_sum[SW-1]) begin
                    pos_y_n = '0;
                    vel_n   = '0;
                    state_n = FALLING;
                end else begin
                    pos_y_n = y_sum[DATA_W-1:0];
                    vel_n   = vel_inc;
                    if (!vel_inc[DATA_W-1])
                        state_n = FALLING;
                end
            end
            FALLING: begin
                if (y_sum >= YGND_S) begin
                    pos_y_n = Y_GND_U;
                    vel_n   = '0;
                    state_n = GROUND;
                end else begin
                    pos_y_n = y_sum[DATA_W-1:0];
                    vel_n   = vel_inc;
                end
            end
            default: begin
                pos_y_n = Y_GND_U;
                vel_n   = '0;
                state_n = GROUND;
            end
        endcase
    end

    // ---- stage p3: frame update, frame_tick aligned with new position ----
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_sync_p0 <= 1'b0;
            frame_sync_p1 <= 1'b0;
            frame_sync_p2 <= 1'b0;
            vld_p3        <= 1'b0;
            pos_x         <= X_START_U;
            pos_y         <= Y_GND_U;
            vel_y         <= '0;
            state         <= GROUND;
            prev_key      <= 8'd0;
        end else begin
            frame_sync_p0 <= bus.frame_clk;
            frame_sync_p1 <= frame_sync_p0;
            frame_sync_p2 <= frame_sync_p1;
            vld_p3        <= tick;
            if (tick) begin
                pos_x    <= move_x(pos_x, bus.keycode);
                pos_y    <= pos_y_n;
                vel_y    <= vel_n;
                state    <= state_n;
                prev_key <= bus.keycode;
            end
        end
    end

    assign bus.PosX       = pos_x;
    assign bus.PosY       = pos_y;
    assign bus.airborne   = (state != GROUND);
    assign bus.frame_tick = vld_p3;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Randomised and directed bench for player_motion_ctrl against a
// trajectory-queue reference model.
module tb_player_motion_ctrl;

    logic Clk = 1'b0;
    logic Reset_n = 1'b1;

    player_motion_ctrl_if bus ();

    player_motion_ctrl dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    int mx;
    int my;
    int mair;
    int mprev;
    int traj[$];

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx    = 320;
        my    = 400;
        mair  = 0;
        mprev = 0;
        traj.delete();
    endtask

    // Whole jump arc precomputed as the list of Y values seen on later frames.
    task automatic plan_jump();
        int y;
        int v;
        bit up;
        y  = 400;
        v  = -12;
        up = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (up) begin
                y = y + v;
                if (y < 0) begin
                    y = 0;
                    v = 0;
                end else begin
                    v = v + 1;
                end
                if (v >= 0) up = 1'b0;
                traj.push_back(y);
            end else begin
                if (y + v >= 400) begin
                    traj.push_back(400);
                    break;
                end
                y = y + v;
                v = v + 1;
                traj.push_back(y);
            end
        end
    endtask

    task automatic model_step(input int k);
        if (k == 4)
            mx = (mx - 2 < 0) ? 0 : mx - 2;
        else if (k == 7)
            mx = (mx + 2 > 631) ? 631 : mx + 2;
        if (traj.size() == 0) begin
            if (k == 26 && mprev != 26) plan_jump();
        end else begin
            my = traj.pop_front();
        end
        mair  = (traj.size() != 0) ? 1 : 0;
        mprev = k;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_x"},   int'(bus.PosX),     mx);
        chk({tag, "_y"},   int'(bus.PosY),     my);
        chk({tag, "_air"}, int'(bus.airborne), mair);
    endtask

    task automatic do_frame(input int k, input string tag);
        int n;
        @(negedge Clk);
        bus.keycode   = 8'(k);
        bus.frame_clk = 1'b1;
        n = 0;
        do begin
            @(posedge Clk);
            #1;
            n++;
        end while (!bus.frame_tick && n < 8);
        model_step(k);
        chk({tag, "_lat"}, n, 3);
        check_outputs(tag);
        @(posedge Clk);
        #1;
        chk({tag, "_pulse"}, int'(bus.frame_tick), 0);
        @(negedge Clk);
        bus.frame_clk = 1'b0;
        repeat (4) @(posedge Clk);
    endtask

    initial begin
        int cnt;
        int peak;
        int r;
        int k;

        bus.frame_clk = 1'b0;
        bus.keycode   = 8'd0;

        // Reset and idle
        #3 Reset_n = 1'b0;
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        check_outputs("rst");
        chk("rst_tick", int'(bus.frame_tick), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(posedge Clk);
            #1;
            if (bus.frame_tick) cnt++;
        end
        chk("idle_tick", cnt, 0);
        check_outputs("idle");

        // Move right for 10 frames
        repeat (10) do_frame(7, "right");
        chk("right10_x", int'(bus.PosX), 340);
        chk("right10_y", int'(bus.PosY), 400);

        // Right edge clamp
        repeat (146) do_frame(7, "toright");
        chk("redge_x", int'(bus.PosX), 631);
        do_frame(4, "redge_l");
        chk("redge_629", int'(bus.PosX), 629);
        do_frame(7, "redge_r1");
        chk("redge_631a", int'(bus.PosX), 631);
        do_frame(7, "redge_r2");
        chk("redge_631b", int'(bus.PosX), 631);

        // Left edge clamp
        repeat (314) do_frame(4, "toleft");
        chk("ledge_3", int'(bus.PosX), 3);
        do_frame(4, "ledge_1");
        chk("ledge_1x", int'(bus.PosX), 1);
        do_frame(4, "ledge_0a");
        chk("ledge_0a_x", int'(bus.PosX), 0);
        do_frame(4, "ledge_0b");
        chk("ledge_0b_x", int'(bus.PosX), 0);

        // Jump with W held
        do_frame(0, "pre_jump");
        do_frame(26, "jump");
        chk("jump_y0", int'(bus.PosY), 400);
        chk("jump_air0", int'(bus.airborne), 1);
        do_frame(26, "jump1");
        chk("jump_y1", int'(bus.PosY), 388);
        do_frame(26, "jump2");
        chk("jump_y2", int'(bus.PosY), 377);
        peak = 400;
        repeat (30) begin
            do_frame(26, "hold");
            if (int'(bus.PosY) < peak) peak = int'(bus.PosY);
        end
        chk("jump_peak", peak, 322);
        chk("no_rejump_air", int'(bus.airborne), 0);
        chk("no_rejump_y", int'(bus.PosY), 400);

        // Alternating W / D every two frames
        for (int i = 0; i < 40; i++) begin
            k = (((i / 2) % 2) != 0) ? 7 : 26;
            do_frame(k, "alt");
        end

        // Reset mid-jump
        repeat (30) do_frame(0, "settle");
        do_frame(26, "rj_jump");
        do_frame(26, "rj_rise");
        chk("rj_rise_air", int'(bus.airborne), 1);
        @(negedge Clk);
        #1 Reset_n = 1'b0;
        #1;
        chk("async_rst_x",   int'(bus.PosX),     320);
        chk("async_rst_y",   int'(bus.PosY),     400);
        chk("async_rst_air", int'(bus.airborne), 0);
        model_reset();
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(posedge Clk);
        do_frame(26, "postrst");
        chk("postrst_air", int'(bus.airborne), 1);

        // Random keycodes
        repeat (300) begin
            r = $urandom_range(0, 9);
            if (r < 3)      k = 26;
            else if (r < 5) k = 4;
            else if (r < 7) k = 7;
            else if (r < 8) k = 0;
            else            k = $urandom_range(0, 255);
            do_frame(k, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
